// File: rtl/mul_issue_queue.sv
// mul_issue_queue: age-ordered issue queue feeding the pipelined multiplier.
// Ports:
//   clk, rst (async, active-low), flush, freeze_back
//   dispatch:  valid_disp, ready_disp, Pw_disp, tag_ROB_disp, Pa_disp, Pb_disp,
//              rdyA_disp, rdyB_disp, busA_disp, busB_disp
//   wakeup:    valid_cdb, Pw_cdb, Result_cdb (port i at [i*W +: W])
//   issue:     valid_mul, Pw_mul, tag_ROB_mul, busA_mul, busB_mul (registered)
module mul_issue_queue #(
    parameter int DEPTH   = 4,
    parameter int DATA_W  = 16,
    parameter int PREG_W  = 5,
    parameter int ROB_W   = 5,
    parameter int NUM_CDB = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      freeze_back,
    input  logic                      valid_disp,
    output logic                      ready_disp,
    input  logic [PREG_W-1:0]         Pw_disp,
    input  logic [ROB_W-1:0]          tag_ROB_disp,
    input  logic [PREG_W-1:0]         Pa_disp,
    input  logic [PREG_W-1:0]         Pb_disp,
    input  logic                      rdyA_disp,
    input  logic                      rdyB_disp,
    input  logic [DATA_W-1:0]         busA_disp,
    input  logic [DATA_W-1:0]         busB_disp,
    input  logic [NUM_CDB-1:0]        valid_cdb,
    input  logic [NUM_CDB*PREG_W-1:0] Pw_cdb,
    input  logic [NUM_CDB*DATA_W-1:0] Result_cdb,
    output logic                      valid_mul,
    output logic [PREG_W-1:0]         Pw_mul,
    output logic [ROB_W-1:0]          tag_ROB_mul,
    output logic [DATA_W-1:0]         busA_mul,
    output logic [DATA_W-1:0]         busB_mul
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    logic [CW-1:0]     count_q, count_d;
    logic [PREG_W-1:0] pw_q [DEPTH], pw_d [DEPTH];
    logic [ROB_W-1:0]  tag_q [DEPTH], tag_d [DEPTH];
    logic [PREG_W-1:0] pa_q [DEPTH], pa_d [DEPTH];
    logic [PREG_W-1:0] pb_q [DEPTH], pb_d [DEPTH];
    logic              rdya_q [DEPTH], rdya_d [DEPTH];
    logic              rdyb_q [DEPTH], rdyb_d [DEPTH];
    logic [DATA_W-1:0] vala_q [DEPTH], vala_d [DEPTH];
    logic [DATA_W-1:0] valb_q [DEPTH], valb_d [DEPTH];

    // Post-wakeup view of the queue; the extra top slot is the zero entry
    // shifted into the last index when an entry collapses out.
    logic [PREG_W-1:0] w_pw [DEPTH+1];
    logic [ROB_W-1:0]  w_tag [DEPTH+1];
    logic [PREG_W-1:0] w_pa [DEPTH+1];
    logic [PREG_W-1:0] w_pb [DEPTH+1];
    logic              w_rdya [DEPTH+1];
    logic              w_rdyb [DEPTH+1];
    logic [DATA_W-1:0] w_vala [DEPTH+1];
    logic [DATA_W-1:0] w_valb [DEPTH+1];

    logic              valid_mul_q, valid_mul_d;
    logic [PREG_W-1:0] pw_mul_q, pw_mul_d;
    logic [ROB_W-1:0]  tag_mul_q, tag_mul_d;
    logic [DATA_W-1:0] busa_mul_q, busa_mul_d;
    logic [DATA_W-1:0] busb_mul_q, busb_mul_d;

    logic          sel_found, issue, accept;
    logic [IW-1:0] sel;
    logic [CW-1:0] wr_idx;
    logic          da_rdy, db_rdy;
    logic [DATA_W-1:0] da_val, db_val;

    // Returns {rdy, value}; ports scanned high-to-low so the lowest matching port wins.
    function automatic logic [DATA_W:0] wake(input logic rdy, input logic [PREG_W-1:0] tag,
                                             input logic [DATA_W-1:0] val);
        logic [DATA_W:0] r;
        r = {rdy, val};
        for (int p = NUM_CDB - 1; p >= 0; p--)
            if (!rdy && valid_cdb[p] && Pw_cdb[p*PREG_W +: PREG_W] == tag)
                r = {1'b1, Result_cdb[p*DATA_W +: DATA_W]};
        return r;
    endfunction

    assign ready_disp  = count_q < CW'(DEPTH);
    assign valid_mul   = valid_mul_q;
    assign Pw_mul      = pw_mul_q;
    assign tag_ROB_mul = tag_mul_q;
    assign busA_mul    = busa_mul_q;
    assign busB_mul    = busb_mul_q;

    always_comb begin
        sel_found = 1'b0;
        sel       = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (i < int'(count_q) && rdya_q[i] && rdyb_q[i]) begin
                sel_found = 1'b1;
                sel       = IW'(i);
            end
        issue   = sel_found && !freeze_back && !flush;
        accept  = valid_disp && ready_disp && !flush;
        wr_idx  = count_q - CW'(issue);
        count_d = flush ? '0 : count_q + CW'(accept) - CW'(issue);
        {da_rdy, da_val} = wake(rdyA_disp, Pa_disp, busA_disp);
        {db_rdy, db_val} = wake(rdyB_disp, Pb_disp, busB_disp);
        w_pw[DEPTH]   = '0;
        w_tag[DEPTH]  = '0;
        w_pa[DEPTH]   = '0;
        w_pb[DEPTH]   = '0;
        w_rdya[DEPTH] = 1'b0;
        w_rdyb[DEPTH] = 1'b0;
        w_vala[DEPTH] = '0;
        w_valb[DEPTH] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_pw[i]  = pw_q[i];
            w_tag[i] = tag_q[i];
            w_pa[i]  = pa_q[i];
            w_pb[i]  = pb_q[i];
            {w_rdya[i], w_vala[i]} = wake(rdya_q[i], pa_q[i], vala_q[i]);
            {w_rdyb[i], w_valb[i]} = wake(rdyb_q[i], pb_q[i], valb_q[i]);
        end
        for (int i = 0; i < DEPTH; i++) begin
            pw_d[i]   = (issue && i >= int'(sel)) ? w_pw[i+1]   : w_pw[i];
            tag_d[i]  = (issue && i >= int'(sel)) ? w_tag[i+1]  : w_tag[i];
            pa_d[i]   = (issue && i >= int'(sel)) ? w_pa[i+1]   : w_pa[i];
            pb_d[i]   = (issue && i >= int'(sel)) ? w_pb[i+1]   : w_pb[i];
            rdya_d[i] = (issue && i >= int'(sel)) ? w_rdya[i+1] : w_rdya[i];
            rdyb_d[i] = (issue && i >= int'(sel)) ? w_rdyb[i+1] : w_rdyb[i];
            vala_d[i] = (issue && i >= int'(sel)) ? w_vala[i+1] : w_vala[i];
            valb_d[i] = (issue && i >= int'(sel)) ? w_valb[i+1] : w_valb[i];
            if (accept && i == int'(wr_idx)) begin
                pw_d[i]   = Pw_disp;
                tag_d[i]  = tag_ROB_disp;
                pa_d[i]   = Pa_disp;
                pb_d[i]   = Pb_disp;
                rdya_d[i] = da_rdy;
                rdyb_d[i] = db_rdy;
                vala_d[i] = da_val;
                valb_d[i] = db_val;
            end
            if (flush) begin
                rdya_d[i] = 1'b0;
                rdyb_d[i] = 1'b0;
            end
        end
        valid_mul_d = flush ? 1'b0 : freeze_back ? valid_mul_q : issue;
        pw_mul_d    = flush ? '0 : issue ? pw_q[sel]   : pw_mul_q;
        tag_mul_d   = flush ? '0 : issue ? tag_q[sel]  : tag_mul_q;
        busa_mul_d  = flush ? '0 : issue ? vala_q[sel] : busa_mul_q;
        busb_mul_d  = flush ? '0 : issue ? valb_q[sel] : busb_mul_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q     <= '0;
            pw_q        <= '{default: '0};
            tag_q       <= '{default: '0};
            pa_q        <= '{default: '0};
            pb_q        <= '{default: '0};
            rdya_q      <= '{default: 1'b0};
            rdyb_q      <= '{default: 1'b0};
            vala_q      <= '{default: '0};
            valb_q      <= '{default: '0};
            valid_mul_q <= 1'b0;
            pw_mul_q    <= '0;
            tag_mul_q   <= '0;
            busa_mul_q  <= '0;
            busb_mul_q  <= '0;
        end else begin
            count_q     <= count_d;
            pw_q        <= pw_d;
            tag_q       <= tag_d;
            pa_q        <= pa_d;
            pb_q        <= pb_d;
            rdya_q      <= rdya_d;
            rdyb_q      <= rdyb_d;
            vala_q      <= vala_d;
            valb_q      <= valb_d;
            valid_mul_q <= valid_mul_d;
            pw_mul_q    <= pw_mul_d;
            tag_mul_q   <= tag_mul_d;
            busa_mul_q  <= busa_mul_d;
            busb_mul_q  <= busb_mul_d;
        end
    end
endmodule

// File: doc/mul_issue_queue.md
# mul_issue_queue

Issue queue for the pipelined multiply unit in the out-of-order back end. It accepts multiply micro-ops from dispatch and holds them until both source operands are available. Operands arrive either with the dispatch or from result-bus (CDB) wakeup broadcasts. Each cycle it issues the oldest ready entry on the multiplier's registered input interface (valid/Pw/ROB tag/busA/busB), and it obeys the back-end flush and freeze_back controls.

## Interface
- DEPTH, 4, number of queue entries (≥2)
- DATA_W, 16, operand width
- PREG_W, 5, physical register index width
- ROB_W, 5, ROB tag width
- NUM_CDB, 2, number of wakeup broadcast ports
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- flush  in  1  squash all entries and the output register
- freeze_back  in  1  back-end stall; hold output register, no issue
- valid_disp  in  1  dispatch request
- ready_disp  out  1  queue can accept; = (count < DEPTH), from registered count
- Pw_disp  in  PREG_W  destination physical register
- tag_ROB_disp  in  ROB_W  ROB tag
- Pa_disp, Pb_disp  in  PREG_W  source physical registers A/B
- rdyA_disp, rdyB_disp  in  1  source already available
- busA_disp, busB_disp  in  DATA_W  source values, meaningful when rdy bit set
- valid_cdb  in  NUM_CDB  broadcast valid per port
- Pw_cdb  in  NUM_CDB*PREG_W  broadcast destination tags, port i at [i*PREG_W +: PREG_W]
- Result_cdb  in  NUM_CDB*DATA_W  broadcast values, same packing
- valid_mul  out  1  registered issue valid to multiplier
- Pw_mul  out  PREG_W  registered
- tag_ROB_mul  out  ROB_W  registered
- busA_mul, busB_mul  out  DATA_W  registered

## Operation
- Storage: collapsing age-ordered array. Entry 0 is the oldest. count ∈ [0, DEPTH]. Per entry: Pw, tag_ROB, Pa, Pb, rdyA, rdyB, valA, valB.
- Select: the lowest-index entry with rdyA & rdyB (registered bits) is chosen, unless freeze_back or flush is asserted.
- Issue: on select, the output register loads the entry fields with valid_mul=1. The entry is removed and entries above it shift down one index.
- No select and no freeze: valid_mul←0; the other outputs hold their previous values.
- freeze_back=1: all output regs hold, including valid_mul. No entry is removed. Wakeup and dispatch still proceed.
- Wakeup: every stored operand with rdy=0 compares its tag against each valid CDB port. On a match it sets rdy=1 and captures the value. If several ports match, the lowest port index wins.
- Dispatch bypass: a dispatched operand with rdy=0 whose tag matches a valid CDB in the same cycle is stored with rdy=1 and the CDB value.
- Dispatch: accepted when valid_disp & ready_disp. It is written at index (count − removed), so a same-cycle issue and dispatch coexist. Requests while ready_disp=0 are ignored.
- count update: count + accepted − issued.
- flush: count←0, all rdy bits←0, all output regs←0. flush takes priority over freeze_back, dispatch, wakeup and issue.
- Reset (rst=0, async): count=0, ready_disp=1, valid_mul=0, Pw_mul=0, tag_ROB_mul=0, busA_mul=0, busB_mul=0, all entry state 0.

## Timing
- Dispatch with both operands ready, accepted at edge k: valid_mul=1 after edge k+1. The minimum dispatch-to-issue latency is 2 edges.
- CDB wakeup at edge k completing an entry: that entry can issue at edge k+1. A wakeup never issues in the same edge it occurs.
- Throughput: 1 issue/cycle when ready entries exist and freeze_back=0.
- ready_disp drops the cycle after count reaches DEPTH. It does not anticipate a same-cycle issue.
- Release from freeze_back: selection resumes on the first edge with freeze_back=0. The held output is overwritten at that edge.
- Reset mid-operation: asynchronous clear regardless of the clock. The first dispatch is accepted at the first edge after rst rises.

## Test plan
- Reset then dispatch Pw=3, tag=7, A=5 (rdy), B=6 (rdy) at edge 1 -> valid_mul=1, Pw_mul=3, tag_ROB_mul=7, busA_mul=5, busB_mul=6 after edge 2; valid_mul=0 after edge 3.
- Dispatch entry X (Pa=9 not ready), then entry Y (fully ready) -> Y issues first. Then CDB port 1 broadcasts Pw=9, value 0x00A0 -> X issues next edge with busA_mul=0x00A0.
- Fill 4 entries, none ready -> ready_disp=0; a 5th valid_disp is ignored. Wake one entry -> it issues, count=3, ready_disp=1 the following cycle.
- Issue in flight with freeze_back held 3 cycles while a ready entry waits -> outputs are unchanged for 3 cycles. The waiting entry issues on the first unfrozen edge, and no entry is lost or duplicated.
- Dispatch with Pb=12 not ready while CDB port 0 broadcasts Pw=12, 0x0033 in the same cycle -> the entry issues 2 edges later with busB_mul=0x0033.
- 3 entries valid plus valid_mul=1, assert flush together with valid_disp -> count=0, valid_mul=0, the dispatch is dropped, and nothing issues afterwards.
